// File: rtl/controller.sv
// Multi-cycle fetch/decode/execute controller for a single-issue core.
// Sequences instruction/data memory handshakes and register-file strobes from a Moore FSM.
module controller #(
    parameter int                  DataSize = 32,
    parameter int                  AddrSize = 5,
    parameter logic [DataSize-1:0] ResetPC  = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    output logic                im_req,
    output logic [DataSize-1:0] im_addr,
    input  logic                im_ack,
    input  logic [DataSize-1:0] im_rdata,
    output logic                dm_req,
    output logic                dm_we,
    input  logic                dm_ack,
    output logic [AddrSize-1:0] read_reg_addr1,
    output logic [AddrSize-1:0] read_reg_addr2,
    output logic [AddrSize-1:0] write_address,
    output logic                do_reg_fetch,
    output logic                do_reg_write,
    output logic                enable_reg_write,
    output logic                write_sel,
    input  logic                alu_zero,
    output logic [DataSize-1:0] ir_out,
    output logic [DataSize-1:0] pc_out,
    output logic                halted
);

    localparam logic [5:0] OP_ALU   = 6'h00;
    localparam logic [5:0] OP_ALUI  = 6'h01;
    localparam logic [5:0] OP_LOAD  = 6'h02;
    localparam logic [5:0] OP_STORE = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JUMP  = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HLT
    } state_t;

    state_t              state_q, state_d;
    logic [DataSize-1:0] pc_q, pc_d;
    logic [DataSize-1:0] ir_q, ir_d;

    logic [5:0]          opcode;
    logic [DataSize-1:0] imm_sx;
    logic [DataSize-1:0] pc_seq;

    assign opcode = ir_q[31:26];
    assign imm_sx = {{(DataSize-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_seq = pc_q + DataSize'(4);

    // Register-file addresses come straight from the IR in every state.
    assign read_reg_addr1 = ir_q[20:16];
    assign read_reg_addr2 = ir_q[15:11];
    assign write_address  = ir_q[25:21];
    assign ir_out         = ir_q;
    assign pc_out         = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= ResetPC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        ir_d             = ir_q;
        im_req           = 1'b0;
        im_addr          = '0;
        dm_req           = 1'b0;
        dm_we            = 1'b0;
        do_reg_fetch     = 1'b0;
        do_reg_write     = 1'b0;
        enable_reg_write = 1'b0;
        write_sel        = 1'b0;
        halted           = 1'b0;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_IF;
            S_IF: begin
                im_req  = 1'b1;
                im_addr = pc_q;
                if (im_ack) begin
                    ir_d    = im_rdata;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                do_reg_fetch = 1'b1;
                state_d      = S_EX;
            end
            S_EX: begin
                pc_d = pc_seq;
                if (opcode == OP_BEQ && alu_zero)
                    pc_d = pc_seq + (imm_sx << 2);
                else if (opcode == OP_JUMP)
                    pc_d = {pc_q[DataSize-1:28], ir_q[25:0], 2'b00};
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_ALU, OP_ALUI:   state_d = S_WB;
                    OP_HALT:           state_d = S_HLT;
                    default:           state_d = S_IF;
                endcase
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = (opcode == OP_STORE);
                if (dm_ack) state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
            end
            S_WB: begin
                do_reg_write     = 1'b1;
                enable_reg_write = (ir_q[25:21] != '0);
                write_sel        = (opcode == OP_LOAD);
                state_d          = S_IF;
            end
            S_HLT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: walks ALU/LOAD/BEQ/JUMP/NOP/STORE/HALT sequences
// and a mid-MEM reset, checking strobes and PC against hand-computed values.
module tb_controller;

    logic        clock = 1'b0;
    logic        reset, run, im_ack, dm_ack, alu_zero;
    logic [31:0] im_rdata;
    logic        im_req, dm_req, dm_we, do_reg_fetch, do_reg_write;
    logic        enable_reg_write, write_sel, halted;
    logic [31:0] im_addr, ir_out, pc_out;
    logic [4:0]  read_reg_addr1, read_reg_addr2, write_address;

    int checks = 0;
    int errors = 0;

    controller dut (
        .clock(clock), .reset(reset), .run(run),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
        .read_reg_addr1(read_reg_addr1), .read_reg_addr2(read_reg_addr2),
        .write_address(write_address),
        .do_reg_fetch(do_reg_fetch), .do_reg_write(do_reg_write),
        .enable_reg_write(enable_reg_write), .write_sel(write_sel),
        .alu_zero(alu_zero), .ir_out(ir_out), .pc_out(pc_out), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // strobe vector: {im_req, dm_req, dm_we, do_reg_fetch, do_reg_write, enable_reg_write, write_sel, halted}
    function automatic logic [31:0] strb();
        return {24'd0, im_req, dm_req, dm_we, do_reg_fetch, do_reg_write,
                enable_reg_write, write_sel, halted};
    endfunction

    localparam logic [31:0] I_ALU3  = 32'h0061_1000; // ALU rd=3 rs1=1 rs2=2
    localparam logic [31:0] I_LOAD5 = 32'h08A1_0000; // LOAD rd=5 rs1=1
    localparam logic [31:0] I_BEQM1 = 32'h1001_FFFF; // BEQ rs1=1 imm=-1
    localparam logic [31:0] I_ALU0  = 32'h0001_1000; // ALU rd=0
    localparam logic [31:0] I_JUMP  = 32'h1400_0010; // JUMP target=0x10
    localparam logic [31:0] I_NOP   = 32'h4000_0000; // opcode 0x10
    localparam logic [31:0] I_STORE = 32'h0C00_0000;
    localparam logic [31:0] I_HALT  = 32'hFC00_0000;

    initial begin
        reset = 1'b1; run = 1'b0; im_ack = 1'b1; dm_ack = 1'b0;
        alu_zero = 1'b0; im_rdata = I_ALU3;
        step(); step();
        reset = 1'b0;
        check("rst_strobes", strb(), 32'h00);
        check("rst_pc", pc_out, 32'h0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_imaddr", im_addr, 32'h0);
        step();
        check("idle_hold", strb(), 32'h00);

        // ALU rd=3, zero-wait fetch
        run = 1'b1;
        step();
        run = 1'b0;
        check("alu_if", strb(), 32'h80);
        check("alu_imaddr", im_addr, 32'h0);
        step();
        check("alu_id", strb(), 32'h10);
        check("alu_ir", ir_out, I_ALU3);
        check("alu_rs1", 32'(read_reg_addr1), 32'd1);
        check("alu_rs2", 32'(read_reg_addr2), 32'd2);
        step();
        check("alu_ex", strb(), 32'h00);
        step();
        check("alu_wb", strb(), 32'h0C);
        check("alu_wa", 32'(write_address), 32'd3);
        check("alu_pc", pc_out, 32'h4);

        // LOAD rd=5: IF held one cycle without ack, dm_ack after 3 wait cycles
        im_ack = 1'b0; im_rdata = I_LOAD5;
        step();
        check("ld_if_wait", strb(), 32'h80);
        step();
        check("ld_if_hold", strb(), 32'h80);
        check("ld_imaddr", im_addr, 32'h4);
        im_ack = 1'b1;
        step();
        check("ld_id", strb(), 32'h10);
        im_ack = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("ld_mem", strb(), 32'h40);
            dm_ack = (i == 3);
        end
        step();
        dm_ack = 1'b0;
        check("ld_wb", strb(), 32'h0E);
        check("ld_wa", 32'(write_address), 32'd5);
        check("ld_pc", pc_out, 32'h8);

        // BEQ imm=-1 at pc=8, taken then not taken
        im_ack = 1'b1; im_rdata = I_BEQM1; alu_zero = 1'b1;
        step();
        check("beq_if", im_addr, 32'h8);
        step();
        step();
        check("beq_t_ex", strb(), 32'h00);
        step();
        check("beq_t_pc", pc_out, 32'h8);
        check("beq_t_back", strb(), 32'h80);
        alu_zero = 1'b0;
        step(); step();
        check("beq_n_ex", strb(), 32'h00);
        step();
        check("beq_n_pc", pc_out, 32'hC);
        check("beq_n_imaddr", im_addr, 32'hC);

        // ALU rd=0 writes nothing
        im_rdata = I_ALU0;
        step(); step(); step();
        check("alu0_wb", strb(), 32'h08);
        check("alu0_pc", pc_out, 32'h10);

        // JUMP then NOP
        im_rdata = I_JUMP;
        step(); step(); step(); step();
        check("jmp_pc", pc_out, 32'h40);
        check("jmp_if", strb(), 32'h80);
        im_rdata = I_NOP;
        step(); step(); step();
        check("nop_pc", pc_out, 32'h44);
        check("nop_if", strb(), 32'h80);

        // STORE
        im_rdata = I_STORE; dm_ack = 1'b1;
        step(); step(); step();
        check("st_mem", strb(), 32'h60);
        step();
        dm_ack = 1'b0;
        check("st_back", strb(), 32'h80);
        check("st_pc", pc_out, 32'h48);

        // LOAD interrupted by reset while in MEM
        im_rdata = I_LOAD5;
        step(); step(); step();
        check("rm_mem", strb(), 32'h40);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_strb", strb(), 32'h00);
        check("rm_pc", pc_out, 32'h0);
        check("rm_ir", ir_out, 32'h0);
        step();
        check("rm_idle", strb(), 32'h00);

        // HALT: sticky, deaf to run and acks
        im_rdata = I_HALT; run = 1'b1;
        step();
        run = 1'b0;
        step(); step(); step();
        check("hlt_enter", strb(), 32'h01);
        for (int i = 0; i < 20; i++) begin
            run = i[0]; im_ack = ~i[0]; dm_ack = i[1];
            step();
            check("hlt_hold", strb(), 32'h01);
        end
        check("hlt_pc", pc_out, 32'h4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("hlt_reset", strb(), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
